// File: rtl/fp_align_rshift.sv
// Pre-add alignment stage for the single-precision adder: unpacks and orders two
// operands by magnitude, then right-shifts the smaller significand with sticky.
module fp_align_rshift #(
  parameter int EW  = 8,
  parameter int MW  = 23,
  parameter int GRS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EW+MW:0]     a,
  input  logic [EW+MW:0]     b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EW-1:0]      exp_big,
  output logic [MW+GRS:0]    man_big,
  output logic [MW+GRS:0]    man_small,
  output logic               sign_big,
  output logic               eff_sub,
  output logic               swap
);

  localparam int W    = MW + 1 + GRS;
  localparam int SW   = MW + 1;
  localparam int LOG2 = $clog2(W);

  // Handshake: a transfer happens on valid & ready at a rising edge. Stage 2
  // loads when it is empty or its result is being taken; stage 1 loads when it
  // is empty or stage 2 loads. in_ready therefore depends on out_ready but never
  // on in_valid, and a stalled result keeps its data outputs unchanged.
  logic s1_valid;
  logic s2_valid;
  logic s2_load;

  assign s2_load   = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_load;
  assign out_valid = s2_valid;

  // ---------------- stage 1: unpack and compare ----------------
  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_frac, b_frac;
  logic [EW-1:0] a_eexp, b_eexp;
  logic [SW-1:0] a_sig, b_sig;
  logic          b_gt;

  logic [EW-1:0] big_eexp, small_eexp;
  logic [SW-1:0] big_sig, small_sig;
  logic          big_sign;

  always_comb begin
    a_exp  = a[EW+MW-1:MW];
    b_exp  = b[EW+MW-1:MW];
    a_frac = a[MW-1:0];
    b_frac = b[MW-1:0];
    // Denormals use exponent 1 so they line up with the smallest normals.
    a_eexp = (a_exp == '0) ? EW'(1) : a_exp;
    b_eexp = (b_exp == '0) ? EW'(1) : b_exp;
    a_sig  = {(a_exp != '0), a_frac};
    b_sig  = {(b_exp != '0), b_frac};
    // Magnitude order on {exp, frac}; a tie keeps A as the big operand.
    b_gt   = b[EW+MW-1:0] > a[EW+MW-1:0];

    big_eexp   = a_eexp;
    small_eexp = b_eexp;
    big_sig    = a_sig;
    small_sig  = b_sig;
    big_sign   = a[EW+MW];
    if (b_gt) begin
      big_eexp   = b_eexp;
      small_eexp = a_eexp;
      big_sig    = b_sig;
      small_sig  = a_sig;
      big_sign   = b[EW+MW];
    end
  end

  logic [EW-1:0] s1_exp_big;
  logic [EW-1:0] s1_diff;
  logic [SW-1:0] s1_sig_big;
  logic [SW-1:0] s1_sig_small;
  logic          s1_sign_big;
  logic          s1_eff_sub;
  logic          s1_swap;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_exp_big   <= '0;
      s1_diff      <= '0;
      s1_sig_big   <= '0;
      s1_sig_small <= '0;
      s1_sign_big  <= 1'b0;
      s1_eff_sub   <= 1'b0;
      s1_swap      <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_exp_big   <= big_eexp;
        s1_diff      <= big_eexp - small_eexp;
        s1_sig_big   <= big_sig;
        s1_sig_small <= small_sig;
        s1_sign_big  <= big_sign;
        s1_eff_sub   <= a[EW+MW] ^ b[EW+MW];
        s1_swap      <= b_gt;
      end
    end
  end

  // ---------------- stage 2: barrel shift with sticky ----------------
  logic [W-1:0]              pre;
  logic [LOG2:0][W-1:0]      lvl;
  logic [LOG2:0]             stk;
  logic                      sat;
  logic [W-1:0]              shifted;

  assign pre    = {s1_sig_small, {GRS{1'b0}}};
  assign lvl[0] = pre;
  assign stk[0] = 1'b0;

  // Each level shifts by 2^k and folds the bits it drops into the sticky.
  for (genvar k = 0; k < LOG2; k++) begin : g_shift
    localparam int SH = 1 << k;
    assign lvl[k+1] = s1_diff[k] ? (lvl[k] >> SH) : lvl[k];
    assign stk[k+1] = stk[k] | (s1_diff[k] & (|lvl[k][SH-1:0]));
  end

  assign sat = (s1_diff >= EW'(W));

  always_comb begin
    shifted = {lvl[LOG2][W-1:1], lvl[LOG2][0] | stk[LOG2]};
    if (sat) begin
      shifted = {{(W-1){1'b0}}, |pre};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      exp_big   <= '0;
      man_big   <= '0;
      man_small <= '0;
      sign_big  <= 1'b0;
      eff_sub   <= 1'b0;
      swap      <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        exp_big   <= s1_exp_big;
        man_big   <= {s1_sig_big, {GRS{1'b0}}};
        man_small <= shifted;
        sign_big  <= s1_sign_big;
        eff_sub   <= s1_eff_sub;
        swap      <= s1_swap;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_rshift.sv
// Bench for fp_align_rshift: directed alignment cases, backpressure, mid-stream
// reset and a randomized stream checked against an arithmetic reference model.
module tb_fp_align_rshift;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  exp_big;
  logic [26:0] man_big;
  logic [26:0] man_small;
  logic        sign_big;
  logic        eff_sub;
  logic        swap;

  fp_align_rshift dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_big   (exp_big),
    .man_big   (man_big),
    .man_small (man_small),
    .sign_big  (sign_big),
    .eff_sub   (eff_sub),
    .swap      (swap)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Result packing: {exp_big[8], man_big[27], man_small[27], sign_big, eff_sub, swap}
  function automatic logic [64:0] model(input logic [31:0] xa, input logic [31:0] xb);
    logic        swp;
    logic [31:0] bg, sm;
    int          eb, es, d;
    longint      mb, pre, ms;
    swp = xb[30:0] > xa[30:0];
    bg  = swp ? xb : xa;
    sm  = swp ? xa : xb;
    eb  = (bg[30:23] == 8'd0) ? 1 : int'(bg[30:23]);
    es  = (sm[30:23] == 8'd0) ? 1 : int'(sm[30:23]);
    d   = eb - es;
    mb  = ((bg[30:23] != 8'd0) ? longint'(64'h800000) : longint'(0)) + longint'(bg[22:0]);
    mb  = mb * 8;
    pre = ((sm[30:23] != 8'd0) ? longint'(64'h800000) : longint'(0)) + longint'(sm[22:0]);
    pre = pre * 8;
    if (d >= 27) begin
      ms = (pre != 0) ? longint'(1) : longint'(0);
    end else begin
      ms = pre >> d;
      if ((pre % (longint'(1) << d)) != 0) ms = ms | longint'(1);
    end
    return {8'(eb), 27'(mb), 27'(ms), bg[31], xa[31] ^ xb[31], swp};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [64:0] exp_q[$];
  logic [64:0] last_got;
  logic [64:0] prev_out;
  logic        prev_stall = 1'b0;
  int          n_out = 0;
  int          acc_cyc = 0;
  int          out_cyc = 0;

  wire [64:0] out_vec = {exp_big, man_big, man_small, sign_big, eff_sub, swap};

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) check("hold_stable", out_vec, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          check("result", out_vec, exp_q.pop_front());
        end
        last_got = out_vec;
        out_cyc  = cyc;
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
        acc_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out_vec;
    end
  end

  // out_ready driver: 0 = stall, 1 = always ready, 2 = random
  int rdy_mode = 1;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returning just after a rising edge.
  task automatic send(input logic [31:0] xa, input logic [31:0] xb);
    int     n;
    logic   done;
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    done     = 1'b0;
    n        = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 1, 0);
  endtask

  task automatic wait_out(input int n_before);
    int n;
    n = 0;
    while (n_out == n_before && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n_out == n_before) check("output_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op(input logic [31:0] ref_op);
    logic [31:0] r;
    int          e;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r = {r[31], 31'd0};
      1: r = {r[31], 8'd0, r[22:0]};
      2: begin
        e = int'(ref_op[30:23]) + int'($urandom_range(0, 8)) - 4;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        r = {r[31], 8'(e), r[22:0]};
      end
      3: r = {r[31], ref_op[30:1], r[0]};
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          n0;
    logic [31:0] ra, rb;

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", out_vec, 0);
    @(posedge clk);
    #1;

    // equal operands, with latency
    n0 = n_out;
    send(32'h3F800000, 32'h3F800000);
    wait_out(n0);
    check("eq_exp_big", last_got[64:57], 8'h7F);
    check("eq_man_big", last_got[56:30], 27'h4000000);
    check("eq_man_small", last_got[29:3], 27'h4000000);
    check("eq_swap_effsub", last_got[1:0], 2'b00);
    check("eq_latency", out_cyc - acc_cyc, 2);

    // shift by one
    n0 = n_out;
    send(32'h3F800000, 32'h3F000000);
    wait_out(n0);
    check("sh1_man_small", last_got[29:3], 27'h2000000);
    check("sh1_swap", last_got[0], 0);

    // swap with sticky
    n0 = n_out;
    send(32'h3F800001, 32'h4B800000);
    wait_out(n0);
    check("swp_swap", last_got[0], 1);
    check("swp_exp_big", last_got[64:57], 8'h97);
    check("swp_man_small", last_got[29:3], 27'h0000005);

    // saturated shift
    n0 = n_out;
    send(32'h7F000000, 32'hBF800000);
    wait_out(n0);
    check("sat_man_small", last_got[29:3], 27'h0000001);
    check("sat_eff_sub", last_got[1], 1);
    check("sat_sign_big", last_got[2], 0);

    // backpressure: two accepted, then in_ready drops
    wait_drain();
    n0 = n_out;
    rdy_mode = 0;
    send(32'h40400000, 32'h3FC00000);
    send(32'hC0000000, 32'h41200000);
    in_valid = 1'b1;
    a = 32'h00000001;
    b = 32'h80000000;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1;
    end
    check("bp_no_output", n_out - n0, 0);
    rdy_mode = 1;
    send(32'h00000001, 32'h80000000);
    send(32'h3F800000, 32'h33800001);
    wait_drain();
    check("bp_count", n_out - n0, 4);

    // reset with two pairs in flight
    send(32'h41000000, 32'h40000000);
    send(32'h42000000, 32'h3E000000);
    n0 = n_out;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    check("flush_none_emitted", n_out - n0, 0);

    // randomized stream with random gaps and backpressure
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      ra = $urandom;
      if ($urandom_range(0, 4) == 0) ra = {ra[31], 8'd0, ra[22:0]};
      rb = rnd_op(ra);
      if ($urandom_range(0, 1) == 1) send(ra, rb);
      else send(rb, ra);
    end
    rdy_mode = 1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
